// File: rtl/pcore_interface_defs.sv
// pcore_interface_defs: data bus request/response types and arbiter constants
package pcore_interface_defs;
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] w_data;
    logic [1:0]  st_ops;
    logic        ld_req;
    logic        st_req;
  } type_lsu2dbus_s;
  typedef struct packed {
    logic [31:0] r_data;
    logic        ack;
  } type_dbus2lsu_s;
  typedef enum logic {ARB_IDLE, ARB_BUSY} type_dbus_arb_state_e;
  localparam logic ARB_M0 = 1'b0;
  localparam logic ARB_M1 = 1'b1;
  localparam int DBUS_ARB_TIMEOUT = 255;
  localparam type_dbus2lsu_s DBUS_ERR_RSP = '{r_data: 32'h0, ack: 1'b1};
endpackage

// File: rtl/dbus_arb_rr.sv
// dbus_arb_rr: two-way round-robin picker; on a tie the master not served last wins
module dbus_arb_rr (
  input  logic [1:0] req,
  input  logic       last_served,
  output logic       gnt_id,
  output logic       gnt_valid
);
  assign gnt_id    = &req ? ~last_served : req[1];
  assign gnt_valid = |req;
endmodule

// File: rtl/dbus_arbiter.sv
// dbus_arbiter: round-robin two-master data bus arbiter with ack timeout
module dbus_arbiter
  import pcore_interface_defs::*;
#(
  parameter int TIMEOUT_CYCLES = DBUS_ARB_TIMEOUT,
  parameter int CNT_W          = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  type_lsu2dbus_s m0_lsu2dbus_i,
  input  type_lsu2dbus_s m1_lsu2dbus_i,
  output type_dbus2lsu_s dbus2m0_o,
  output type_dbus2lsu_s dbus2m1_o,
  output type_lsu2dbus_s lsu2dbus_o,
  input  type_dbus2lsu_s dbus2lsu_i,
  output logic           busy_o,
  output logic           owner_o,
  output logic           bus_err_o,
  output logic [31:0]    err_addr_o
);
  type_dbus_arb_state_e state;
  logic                 owner, last_served, gnt_id, gnt_valid;
  logic                 busy, owner_req, tc, timeout;
  logic [1:0]           req;
  logic [CNT_W-1:0]     cnt;
  type_lsu2dbus_s       owner_sel;
  type_dbus2lsu_s       owner_rsp;

  assign req       = {m1_lsu2dbus_i.ld_req | m1_lsu2dbus_i.st_req,
                      m0_lsu2dbus_i.ld_req | m0_lsu2dbus_i.st_req};
  assign busy      = state == ARB_BUSY;
  assign owner_req = req[owner];
  assign owner_sel = owner == ARB_M1 ? m1_lsu2dbus_i : m0_lsu2dbus_i;
  assign tc        = cnt == CNT_W'(TIMEOUT_CYCLES - 1);
  // a real ack at terminal count beats the synthesized error
  assign timeout   = busy & owner_req & ~dbus2lsu_i.ack & tc;
  assign owner_rsp = !busy ? '0 : timeout ? DBUS_ERR_RSP : dbus2lsu_i;

  assign lsu2dbus_o = busy & owner_req ? owner_sel : '0;
  assign dbus2m0_o  = owner == ARB_M0 ? owner_rsp : '0;
  assign dbus2m1_o  = owner == ARB_M1 ? owner_rsp : '0;
  assign busy_o     = busy;
  assign owner_o    = owner;
  assign bus_err_o  = timeout;

  dbus_arb_rr u_rr (
    .req         (req),
    .last_served (last_served),
    .gnt_id      (gnt_id),
    .gnt_valid   (gnt_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ARB_IDLE;
      owner       <= ARB_M0;
      last_served <= ARB_M1;
      cnt         <= '0;
      err_addr_o  <= '0;
    end else if (!busy) begin
      cnt <= '0;
      if (gnt_valid) begin
        owner <= gnt_id;
        state <= ARB_BUSY;
      end
    end else if (dbus2lsu_i.ack || !owner_req || tc) begin
      state       <= ARB_IDLE;
      last_served <= owner;
      cnt         <= '0;
      if (timeout) err_addr_o <= owner_sel.addr;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule
